squeezer_ctrl: RTL and testbench
================================

// Module: squeezer_ctrl
// PURPOSE
//  Sequencer for one carry-save modular multiplication through the squeezer datapath.
//  Scans multiplier b MSB-first; per bit: double, squeeze, then add+squeeze if bit set.
//  Finishes with FINAL_SQZ extra squeeze passes and returns a valid/ready completion.
//  Sits between the modmul top level and the accumulator/squeezer-rule datapath.
// PARAMETERS
//  N          1<<9           operand width; b length and iteration count
//  FINAL_SQZ  2              squeeze passes after the last bit (>=1)
//  CW         $clog2(N)+1    width of iter and sqz_cnt
// PORTS
//  clk         in   1      clock, rising edge
//  rst         in   1      synchronous reset, active-high
//  start       in   1      request; accepted only in IDLE
//  b           in   N      multiplier; captured into shift reg on accept
//  busy        out  1      high in all states except IDLE
//  rule_in     in   3      rule from the squeezer-rule block (legal 0..5)
//  acc_clr     out  1      clear accumulator (LOAD only)
//  dbl_en      out  1      accumulator <<= 1 (DBL only)
//  add_en      out  1      accumulator += a (ADD only)
//  sqz_en      out  1      apply squeeze correction (SQZ/FIN only)
//  sqz_rule    out  3      = rule_in while sqz_en, else 0 (combinational)
//  iter        out  CW     bits remaining, incl. current; 0 outside the bit loop
//  sqz_cnt     out  CW     squeezes with rule!=0 this operation
//  err         out  1      sticky: rule_in 6/7 seen while sqz_en
//  done_valid  out  1      result ready; held until done_ready
//  done_ready  in   1      consumer accepts completion
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; shift reg, iter, sqz_cnt, err cleared.
//  Reset wins over every other event and aborts any operation in progress at once.
//  All enables are decoded from the registered state; one-hot at most (one per cycle).
//  FSM: IDLE -> LOAD -> DBL -> SQZ -> [ADD -> SQZ2] -> DBL ... -> FIN x FINAL_SQZ -> DONE
//   IDLE: start=1 -> capture b, iter<=N, sqz_cnt<=0, err<=0; next LOAD.
//   LOAD: acc_clr=1; next DBL.
//   DBL:  dbl_en=1; next SQZ.
//   SQZ:  sqz_en=1; if b_sh[N-1] next ADD. Otherwise, when iter==1, next FIN, else next DBL.
//         On DBL, shift b_sh left by 1 and decrement iter.
//   ADD:  add_en=1; next SQZ2.
//   SQZ2: sqz_en=1; then follows the same iter/shift rule as the no-add exit from SQZ.
//   FIN:  sqz_en=1; repeats FINAL_SQZ cycles using an internal counter; next DONE.
//   DONE: done_valid=1, busy=1; on done_ready -> IDLE.
//  Latency, accept edge to done_valid: 1 + 2N + 2*popcount(b) + FINAL_SQZ + 1 cycles.
//  start outside IDLE is ignored, including during DONE with done_ready=1.
//   The requester must reassert start once busy=0.
//  sqz_cnt increments on any sqz_en cycle with rule_in!=0 and saturates at all-ones.
//  err is set on any sqz_en cycle with rule_in>5; the operation still completes.
//   err holds until the next accepted start or rst.
//  b=0: no ADD states occur. b=all-ones: every bit takes 4 cycles.
// TESTING
//  N=8,FINAL_SQZ=2, b=8'h00, rule_in=0 -> done_valid 20 cycles after accept.
//   add_en never high; sqz_cnt=0.
//  N=8, b=8'hFF -> latency 36 cycles; add_en pulses 8 times; iter sequence 8..1.
//  N=8, b=8'h81, rule_in=3 constant -> sqz_en cycles=12; sqz_cnt=12; err=0.
//  rule_in=7 on one SQZ cycle -> err=1 until next start.
//   done still asserts at nominal latency.
//  start pulses while busy and in DONE with done_ready=1 -> ignored; next op only after IDLE.
//  rst asserted mid-ADD -> next cycle busy=0, all enables 0, done_valid=0, err=0.

Source files
------------

// File: rtl/squeezer_ctrl.sv
// Sequencer for one carry-save modular multiplication through the squeezer datapath.
// Scans b MSB-first (double, squeeze, optional add+squeeze), then runs the final squeezes.
module squeezer_ctrl #(
    parameter int N         = 1 << 9,
    parameter int FINAL_SQZ = 2,
    parameter int CW        = $clog2(N) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [N-1:0]  b,
    output logic          busy,
    input  logic [2:0]    rule_in,
    output logic          acc_clr,
    output logic          dbl_en,
    output logic          add_en,
    output logic          sqz_en,
    output logic [2:0]    sqz_rule,
    output logic [CW-1:0] iter,
    output logic [CW-1:0] sqz_cnt,
    output logic          err,
    output logic          done_valid,
    input  logic          done_ready
);

    localparam int FW = (FINAL_SQZ > 1) ? $clog2(FINAL_SQZ) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DBL,
        SQZ,
        ADD,
        SQZ2,
        FIN,
        DONE
    } state_t;

    state_t        state;
    logic [N-1:0]  b_sh;
    logic [FW-1:0] fin_cnt;

    // Moore outputs decoded straight from the state register, so at most one enable is high.
    assign busy       = (state != IDLE);
    assign acc_clr    = (state == LOAD);
    assign dbl_en     = (state == DBL);
    assign add_en     = (state == ADD);
    assign sqz_en     = (state == SQZ) || (state == SQZ2) || (state == FIN);
    assign done_valid = (state == DONE);
    assign sqz_rule   = sqz_en ? rule_in : 3'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            b_sh    <= '0;
            iter    <= '0;
            sqz_cnt <= '0;
            err     <= 1'b0;
            fin_cnt <= '0;
        end else begin
            if (sqz_en && (rule_in != 3'd0) && (sqz_cnt != '1))
                sqz_cnt <= sqz_cnt + 1'b1;
            if (sqz_en && (rule_in > 3'd5))
                err <= 1'b1;

            case (state)
                IDLE: begin
                    if (start) begin
                        b_sh    <= b;
                        iter    <= CW'(N);
                        sqz_cnt <= '0;
                        err     <= 1'b0;
                        state   <= LOAD;
                    end
                end
                LOAD: state <= DBL;
                DBL:  state <= SQZ;
                ADD:  state <= SQZ2;
                // SQZ2 shares the bit-advance exit; only SQZ may branch into ADD.
                SQZ, SQZ2: begin
                    if ((state == SQZ) && b_sh[N-1]) begin
                        state <= ADD;
                    end else if (iter == CW'(1)) begin
                        iter    <= '0;
                        fin_cnt <= FW'(FINAL_SQZ - 1);
                        state   <= FIN;
                    end else begin
                        b_sh  <= b_sh << 1;
                        iter  <= iter - 1'b1;
                        state <= DBL;
                    end
                end
                FIN: begin
                    if (fin_cnt == '0)
                        state <= DONE;
                    else
                        fin_cnt <= fin_cnt - 1'b1;
                end
                DONE: begin
                    if (done_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_squeezer_ctrl.sv
// Self-checking bench for squeezer_ctrl: a per-cycle operation list built from b
// predicts enables, iter and completion; rule statistics are modelled alongside.
module tb_squeezer_ctrl;

    localparam int N  = 8;
    localparam int FS = 2;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst, start, done_ready;
    logic [N-1:0]  b;
    logic [2:0]    rule_in, sqz_rule;
    logic          busy, acc_clr, dbl_en, add_en, sqz_en, err, done_valid;
    logic [CW-1:0] iter, sqz_cnt;

    int checks = 0;
    int errors = 0;

    logic [3:0] exp_ops[$];
    int         exp_iter[$];
    int         model_cnt;
    bit         model_err;

    squeezer_ctrl #(.N(N), .FINAL_SQZ(FS)) dut (
        .clk(clk), .rst(rst), .start(start), .b(b), .busy(busy),
        .rule_in(rule_in), .acc_clr(acc_clr), .dbl_en(dbl_en), .add_en(add_en),
        .sqz_en(sqz_en), .sqz_rule(sqz_rule), .iter(iter), .sqz_cnt(sqz_cnt),
        .err(err), .done_valid(done_valid), .done_ready(done_ready)
    );

    always #5 clk = ~clk;

    // Expected cycle list {clr,dbl,add,sqz} and bits-remaining, straight from the bit-scan rules.
    function automatic void build_model(input logic [N-1:0] bv);
        exp_ops.delete();
        exp_iter.delete();
        exp_ops.push_back(4'b1000); exp_iter.push_back(N);
        for (int i = N - 1; i >= 0; i--) begin
            exp_ops.push_back(4'b0100); exp_iter.push_back(i + 1);
            exp_ops.push_back(4'b0001); exp_iter.push_back(i + 1);
            if (bv[i]) begin
                exp_ops.push_back(4'b0010); exp_iter.push_back(i + 1);
                exp_ops.push_back(4'b0001); exp_iter.push_back(i + 1);
            end
        end
        for (int f = 0; f < FS; f++) begin
            exp_ops.push_back(4'b0001); exp_iter.push_back(0);
        end
    endfunction

    task automatic wait_idle();
        int guard = 0;
        while (busy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("[TB] FAIL idle_timeout: busy got %b want 0", busy);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
        end
    endtask

    // rule_mode: 0 zero, 1 random 0..5, 2 constant 3, 3 a single 7 on one SQZ, 4 random 0..7
    task automatic run_op(input logic [N-1:0] bv, input int rule_mode, input bit poke_start,
                          input int ready_delay, output int adds_seen, output int sqz_seen,
                          output int final_cnt, output bit final_err);
        logic [2:0] r;
        bit injected = 1'b0;
        adds_seen = 0;
        sqz_seen  = 0;
        wait_idle();
        @(negedge clk);
        start = 1'b1; b = bv; done_ready = 1'b0; rule_in = 3'd0;
        model_cnt = 0; model_err = 1'b0;
        build_model(bv);
        for (int k = 0; k < exp_ops.size(); k++) begin
            @(negedge clk);
            start = poke_start ? 1'($urandom_range(0, 1)) : 1'b0;
            b = N'($urandom);
            case (rule_mode)
                0: r = 3'd0;
                1: r = 3'($urandom_range(0, 5));
                2: r = 3'd3;
                3: begin
                    r = 3'd0;
                    if (!injected && exp_ops[k] == 4'b0001 && k > 4) begin
                        r = 3'd7;
                        injected = 1'b1;
                    end
                end
                default: r = 3'($urandom_range(0, 7));
            endcase
            rule_in = r;
            #1;
            checks++;
            if ({acc_clr, dbl_en, add_en, sqz_en} !== exp_ops[k]) begin
                errors++;
                $display("[TB] FAIL enables cycle %0d: got %b want %b", k + 1,
                         {acc_clr, dbl_en, add_en, sqz_en}, exp_ops[k]);
            end
            checks++;
            if (iter !== CW'(exp_iter[k])) begin
                errors++;
                $display("[TB] FAIL iter cycle %0d: got %0d want %0d", k + 1, iter, exp_iter[k]);
            end
            checks++;
            if (sqz_rule !== (exp_ops[k][0] ? r : 3'd0)) begin
                errors++;
                $display("[TB] FAIL sqz_rule cycle %0d: got %0d want %0d", k + 1, sqz_rule,
                         exp_ops[k][0] ? r : 3'd0);
            end
            checks++;
            if (busy !== 1'b1 || done_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL busy_done cycle %0d: got %b%b want 10", k + 1, busy, done_valid);
            end
            checks++;
            if (sqz_cnt !== CW'(model_cnt) || err !== model_err) begin
                errors++;
                $display("[TB] FAIL stats cycle %0d: got cnt %0d err %b want cnt %0d err %b",
                         k + 1, sqz_cnt, err, model_cnt, model_err);
            end
            if (exp_ops[k][0]) begin
                if (r != 3'd0 && model_cnt < (1 << CW) - 1) model_cnt++;
                if (r > 3'd5) model_err = 1'b1;
            end
            adds_seen += int'(add_en);
            sqz_seen  += int'(sqz_en);
        end
        // Completion must appear exactly at the nominal latency and hold until accepted.
        for (int d = 0; d <= ready_delay; d++) begin
            @(negedge clk);
            start = poke_start;
            rule_in = 3'($urandom_range(0, 7));
            #1;
            checks++;
            if (done_valid !== 1'b1 || busy !== 1'b1 ||
                {acc_clr, dbl_en, add_en, sqz_en} !== 4'b0000 || iter !== '0) begin
                errors++;
                $display("[TB] FAIL done_state wait %0d: got dv %b busy %b en %b iter %0d want 1 1 0000 0",
                         d, done_valid, busy, {acc_clr, dbl_en, add_en, sqz_en}, iter);
            end
            checks++;
            if (sqz_cnt !== CW'(model_cnt) || err !== model_err) begin
                errors++;
                $display("[TB] FAIL done_stats: got cnt %0d err %b want cnt %0d err %b",
                         sqz_cnt, err, model_cnt, model_err);
            end
        end
        final_cnt = int'(sqz_cnt);
        final_err = err;
        done_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; done_ready = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done_valid !== 1'b0 || err !== model_err) begin
            errors++;
            $display("[TB] FAIL release: got busy %b dv %b err %b want 0 0 %b",
                     busy, done_valid, err, model_err);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stray_start: busy got %b want 0", busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rule_in = 3'd7;
        #1;
        checks++;
        if ({busy, acc_clr, dbl_en, add_en, sqz_en, err, done_valid} !== 7'b0 ||
            sqz_rule !== 3'd0 || iter !== '0 || sqz_cnt !== '0) begin
            errors++;
            $display("[TB] FAIL reset: got flags %b rule %0d iter %0d cnt %0d want all 0",
                     {busy, acc_clr, dbl_en, add_en, sqz_en, err, done_valid}, sqz_rule, iter, sqz_cnt);
        end
        rst = 1'b0;
        rule_in = 3'd0;
    endtask

    task automatic test_zero_b();
        int adds, sqzs, cnt; bit e;
        run_op(8'h00, 0, 1'b0, 0, adds, sqzs, cnt, e);
        checks++;
        if (adds !== 0 || cnt !== 0) begin
            errors++;
            $display("[TB] FAIL zero_b: got adds %0d cnt %0d want 0 0", adds, cnt);
        end
    endtask

    task automatic test_all_ones();
        int adds, sqzs, cnt; bit e;
        run_op(8'hFF, 1, 1'b0, 2, adds, sqzs, cnt, e);
        checks++;
        if (adds !== 8 || sqzs !== 18) begin
            errors++;
            $display("[TB] FAIL all_ones: got adds %0d sqz %0d want 8 18", adds, sqzs);
        end
    endtask

    task automatic test_rule_count();
        int adds, sqzs, cnt; bit e;
        run_op(8'h81, 2, 1'b0, 0, adds, sqzs, cnt, e);
        checks++;
        if (sqzs !== 12 || cnt !== 12 || e !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rule_count: got sqz %0d cnt %0d err %b want 12 12 0", sqzs, cnt, e);
        end
    endtask

    task automatic test_err();
        int adds, sqzs, cnt; bit e;
        run_op(8'h5A, 3, 1'b0, 1, adds, sqzs, cnt, e);
        checks++;
        if (e !== 1'b1) begin
            errors++;
            $display("[TB] FAIL err_sticky: got %b want 1", e);
        end
        run_op(8'h33, 0, 1'b0, 0, adds, sqzs, cnt, e);
        checks++;
        if (e !== 1'b0) begin
            errors++;
            $display("[TB] FAIL err_clear: got %b want 0", e);
        end
    endtask

    task automatic test_start_ignored();
        int adds, sqzs, cnt; bit e;
        run_op(8'hC3, 1, 1'b1, 1, adds, sqzs, cnt, e);
        checks++;
        if (adds !== 4) begin
            errors++;
            $display("[TB] FAIL start_ignored: got adds %0d want 4", adds);
        end
    endtask

    task automatic test_reset_mid_add();
        wait_idle();
        @(negedge clk);
        start = 1'b1; b = 8'h80; rule_in = 3'd0;
        // LOAD, DBL, then SQZ with an illegal rule so err is set before the abort.
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            rule_in = (c == 3) ? 3'd7 : 3'd0;
        end
        @(negedge clk);
        rule_in = 3'd0;
        #1;
        checks++;
        if (add_en !== 1'b1 || err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pre_abort: got add %b err %b want 1 1", add_en, err);
        end
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if ({busy, acc_clr, dbl_en, add_en, sqz_en, done_valid, err} !== 7'b0 ||
            iter !== '0 || sqz_cnt !== '0) begin
            errors++;
            $display("[TB] FAIL abort: got flags %b iter %0d cnt %0d want all 0",
                     {busy, acc_clr, dbl_en, add_en, sqz_en, done_valid, err}, iter, sqz_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        int adds, sqzs, cnt; bit e;
        logic [N-1:0] bv;
        for (int t = 0; t < 6; t++) begin
            bv = N'($urandom);
            run_op(bv, 4, 1'($urandom_range(0, 1)), $urandom_range(0, 3), adds, sqzs, cnt, e);
            checks++;
            if (adds !== $countones(bv)) begin
                errors++;
                $display("[TB] FAIL random_adds b=%h: got %0d want %0d", bv, adds, $countones(bv));
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; done_ready = 1'b0; b = '0; rule_in = 3'd0;
        test_reset();
        test_zero_b();
        test_all_ones();
        test_rule_count();
        test_err();
        test_start_ignored();
        test_reset_mid_add();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
